// File: rtl/adiabatic_pclk_gen.sv
// Four-phase power-clock generator for two-stage adiabatic logic emulation.
// Runs bursts of whole periods and strobes the last cycle of quarter 1 as the stage-2 sample point.
module adiabatic_pclk_gen #(
    parameter int STEP_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] quarter,
    input  logic [CNT_W-1:0]  burst,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              clkpos,
    output logic              clkneg,
    output logic              clkpos2,
    output logic              clkneg2,
    output logic [1:0]        phase,
    output logic              sample
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [STEP_W-1:0] r_qlen, w_qlen_nxt;
    logic [STEP_W-1:0] r_step, w_step_nxt;
    logic [CNT_W-1:0]  r_remaining, w_remaining_nxt;
    logic              r_cont, w_cont_nxt;
    logic              r_stop_pend, w_stop_pend_nxt;
    logic [1:0]        r_phase, w_phase_nxt;
    logic              w_done_nxt;
    logic              w_qend, w_period_end, w_run_nxt;

    logic r_busy, r_done, r_clkpos, r_clkneg, r_clkpos2, r_clkneg2, r_sample;

    assign w_qend       = (r_step == r_qlen);
    assign w_period_end = w_qend && (r_phase == 2'd3);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and a latch is never inferred.
        w_state_nxt     = r_state;
        w_qlen_nxt      = r_qlen;
        w_step_nxt      = r_step;
        w_remaining_nxt = r_remaining;
        w_cont_nxt      = r_cont;
        w_stop_pend_nxt = r_stop_pend;
        w_phase_nxt     = r_phase;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt     = S_RUN;
                    w_qlen_nxt      = quarter;
                    w_remaining_nxt = burst;
                    w_cont_nxt      = (burst == '0);
                    w_step_nxt      = '0;
                    w_phase_nxt     = 2'd0;
                    w_stop_pend_nxt = stop;
                end
            end
            S_RUN: begin
                w_stop_pend_nxt = r_stop_pend | stop;
                if (w_qend) begin
                    w_step_nxt  = '0;
                    w_phase_nxt = r_phase + 2'd1;
                end else begin
                    w_step_nxt  = r_step + STEP_W'(1);
                end
                // A stop seen on the final quarter-3 cycle still ends this period.
                if (w_period_end) begin
                    if (r_stop_pend || stop || (!r_cont && r_remaining == CNT_W'(1))) begin
                        w_state_nxt     = S_IDLE;
                        w_done_nxt      = 1'b1;
                        w_stop_pend_nxt = 1'b0;
                        w_phase_nxt     = 2'd0;
                    end else if (!r_cont) begin
                        w_remaining_nxt = r_remaining - CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_run_nxt = (w_state_nxt == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_qlen      <= '0;
            r_step      <= '0;
            r_remaining <= '0;
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_phase     <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_clkpos    <= 1'b0;
            r_clkneg    <= 1'b1;
            r_clkpos2   <= 1'b0;
            r_clkneg2   <= 1'b1;
            r_sample    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only here; outputs are registered from next-state so complements flip on the same edge.
            r_state     <= w_state_nxt;
            r_qlen      <= w_qlen_nxt;
            r_step      <= w_step_nxt;
            r_remaining <= w_remaining_nxt;
            r_cont      <= w_cont_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_phase     <= w_phase_nxt;
            r_busy      <= w_run_nxt;
            r_done      <= w_done_nxt;
            r_clkpos    <= w_run_nxt && !w_phase_nxt[1];
            r_clkneg    <= !(w_run_nxt && !w_phase_nxt[1]);
            r_clkpos2   <= w_run_nxt && (w_phase_nxt[1] ^ w_phase_nxt[0]);
            r_clkneg2   <= !(w_run_nxt && (w_phase_nxt[1] ^ w_phase_nxt[0]));
            r_sample    <= w_run_nxt && (w_phase_nxt == 2'd1) && (w_step_nxt == w_qlen_nxt);
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign clkpos  = r_clkpos;
    assign clkneg  = r_clkneg;
    assign clkpos2 = r_clkpos2;
    assign clkneg2 = r_clkneg2;
    assign phase   = r_phase;
    assign sample  = r_sample;

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// Self-checking bench: cycle-index model of the power-clock bursts plus directed literal expectations.
module tb_adiabatic_pclk_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] quarter = '0;
    logic [7:0] burst = '0;
    logic       stop = 1'b0;
    logic       busy, done, clkpos, clkneg, clkpos2, clkneg2, sample;
    logic [1:0] phase;

    adiabatic_pclk_gen #(.STEP_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .quarter(quarter), .burst(burst),
        .stop(stop), .busy(busy), .done(done), .clkpos(clkpos), .clkneg(clkneg),
        .clkpos2(clkpos2), .clkneg2(clkneg2), .phase(phase), .sample(sample)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is a cycle index k from its start; quarter and position follow by division.
    bit m_active = 1'b0;
    bit m_done = 1'b0;
    bit m_pend = 1'b0;
    int m_k = 0;
    int m_q = 0;
    int m_n = 0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_pend   <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_q      <= int'(quarter);
                m_n      <= int'(burst);
                m_pend   <= stop;
            end
        end else if (((m_k + 1) % (4 * (m_q + 1)) == 0) &&
                     (m_pend || stop || (m_n != 0 && (m_k + 1) / (4 * (m_q + 1)) == m_n))) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
            m_pend   <= 1'b0;
            m_k      <= 0;
        end else begin
            m_k    <= m_k + 1;
            m_pend <= m_pend | stop;
        end
    end

    function automatic logic [8:0] expected_vec();
        int  eq;
        int  es;
        bit  p1;
        bit  p2;
        bit  smp;
        eq  = (m_k / (m_q + 1)) % 4;
        es  = m_k % (m_q + 1);
        p1  = m_active && (eq < 2);
        p2  = m_active && (eq == 1 || eq == 2);
        smp = m_active && (eq == 1) && (es == m_q);
        return {m_active, m_done, p1, !p1, p2, !p2, (m_active ? 2'(eq) : 2'd0), smp};
    endfunction

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en)
            check("cycle_outputs",
                  32'({busy, done, clkpos, clkneg, clkpos2, clkneg2, phase, sample}),
                  32'(expected_vec()));
    end

    logic [79:0] cap_cp, cap_cp2;
    int cap_busy, cap_done, cap_s1, cap_s2;

    // Launches a burst and records its waveform; cycle 1 is the first cycle after the accepting edge.
    task automatic run_burst(input bit now, input logic [3:0] q, input logic [7:0] b,
                             input logic st, input int stop_at, input int start_at,
                             input int rst_at, input int maxc);
        cap_cp = '0; cap_cp2 = '0;
        cap_busy = 0; cap_done = -1; cap_s1 = -1; cap_s2 = -1;
        if (!now) @(negedge clk);
        start = 1'b1; quarter = q; burst = b; stop = st;
        @(negedge clk);
        for (int c = 1; c <= maxc; c++) begin
            start = 1'b0; stop = 1'b0; rst = 1'b0;
            if (c <= 80) begin
                cap_cp[c-1]  = clkpos;
                cap_cp2[c-1] = clkpos2;
            end
            if (busy) cap_busy++;
            if (sample) begin
                if (cap_s1 < 0) cap_s1 = c;
                else if (cap_s2 < 0) cap_s2 = c;
            end
            if (c == stop_at) stop = 1'b1;
            if (c == start_at) begin
                start = 1'b1; quarter = 4'd5; burst = 8'd7;
            end
            if (c == rst_at) rst = 1'b1;
            if (done) begin
                cap_done = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_values", 32'({busy, done, clkpos, clkneg, clkpos2, clkneg2, phase, sample}),
              32'(9'b000101000));
        cmp_en = 1'b1;
        rst = 1'b0;

        run_burst(0, 4'd0, 8'd2, 1'b0, 0, 0, 0, 30);
        check("q0_clkpos",  32'(cap_cp[7:0]),  32'h33);
        check("q0_clkpos2", 32'(cap_cp2[7:0]), 32'h66);
        check("q0_busy",    cap_busy, 8);
        check("q0_done",    cap_done, 9);
        check("q0_sample1", cap_s1, 2);
        check("q0_sample2", cap_s2, 6);

        run_burst(0, 4'd3, 8'd1, 1'b0, 0, 0, 0, 40);
        check("q3_clkpos",  32'(cap_cp[15:0]),  32'h00FF);
        check("q3_clkpos2", 32'(cap_cp2[15:0]), 32'h0FF0);
        check("q3_busy",    cap_busy, 16);
        check("q3_done",    cap_done, 17);

        run_burst(0, 4'd1, 8'd0, 1'b0, 35, 0, 0, 60);
        check("cont_busy", cap_busy, 40);
        check("cont_done", cap_done, 41);

        run_burst(0, 4'd0, 8'd2, 1'b0, 0, 3, 0, 30);
        check("ign_clkpos", 32'(cap_cp[7:0]), 32'h33);
        check("ign_busy",   cap_busy, 8);
        check("ign_done",   cap_done, 9);
        run_burst(1, 4'd0, 8'd1, 1'b0, 0, 0, 0, 30);
        check("b2b_first",  32'(cap_cp[0]), 1);
        check("b2b_busy",   cap_busy, 4);
        check("b2b_done",   cap_done, 5);

        run_burst(0, 4'd1, 8'd3, 1'b0, 0, 0, 5, 30);
        check("rst_busy", cap_busy, 5);
        check("rst_done", cap_done, -1);
        run_burst(0, 4'd2, 8'd1, 1'b0, 0, 0, 0, 30);
        check("post_rst_busy", cap_busy, 12);
        check("post_rst_done", cap_done, 13);

        run_burst(0, 4'd0, 8'd0, 1'b1, 0, 0, 0, 30);
        check("stop_accept_busy", cap_busy, 4);
        check("stop_accept_done", cap_done, 5);

        run_burst(0, 4'd1, 8'd3, 1'b0, 8, 0, 0, 40);
        check("stop_lastq3_done", cap_done, 9);
        run_burst(0, 4'd1, 8'd3, 1'b0, 7, 0, 0, 40);
        check("stop_q3_done", cap_done, 9);

        run_burst(0, 4'd15, 8'd1, 1'b0, 0, 0, 0, 80);
        check("q15_busy",    cap_busy, 64);
        check("q15_done",    cap_done, 65);
        check("q15_sample",  cap_s1, 32);
        check("q15_clkpos2", 32'(cap_cp2[63:32]), 32'h0000FFFF);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
